// File: rtl/dsi_deskew_pkg.sv
// Shared types and constants for the D-PHY lane deskew / word packer.
package dsi_deskew_pkg;

  localparam int NUM_LANES      = 4;
  localparam int LANE_W         = 8;
  localparam int WORD_W         = NUM_LANES * LANE_W;
  localparam int DEF_MAX_SKEW   = 3;
  localparam int DEF_FIFO_DEPTH = 4;

  // word_count stops here instead of wrapping on very long bursts
  localparam logic [15:0] WC_SAT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ALL = 2'd1,
    STREAM   = 2'd2,
    FAIL     = 2'd3
  } state_t;

endpackage

// File: rtl/lane_skew_fifo.sv
// Per-lane skew buffer: small synchronous FIFO with flush and an occupancy count.
// Read data is combinational from the head entry so the packer can register it on pop.
module lane_skew_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          byte_clk,
  input  logic          sys_rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wr_data,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_en, rd_en;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A full FIFO still accepts a write when the head leaves on the same edge
  assign wr_en   = push && (!full || pop);
  assign rd_en   = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy tracking; flush drops everything in one edge
  always_ff @(posedge byte_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= next_ptr(wr_ptr);
      if (rd_en) rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

  // Storage array; contents are don't-care while empty so it carries no reset
  always_ff @(posedge byte_clk) begin
    if (wr_en && !flush) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/dsi_lane_deskew_packer.sv
// Deskews four HS lane byte streams and packs them into one 32-bit word per byte_clk.
// data_out_valid is a pure qualifier with no backpressure: the consumer takes every
// cycle it is high, and each contiguous valid run is one burst.
module dsi_lane_deskew_packer
  import dsi_deskew_pkg::*;
#(
  parameter int MAX_SKEW   = DEF_MAX_SKEW,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic        byte_clk,
  input  logic        sys_rst_n,
  input  logic        enable_i,
  input  logic [3:0]  lane_valid_i,
  input  logic [31:0] lane_data_i,
  output logic        data_out_valid,
  output logic [31:0] data_out,
  output logic        align_fail,
  output logic [15:0] word_count,
  output logic [1:0]  state_dbg
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(MAX_SKEW + 2);

  state_t               state_q, state_d;
  logic [NUM_LANES-1:0] started_q, started_d, ended_q, ended_d;
  logic [SW-1:0]        skew_cnt_q, skew_cnt_d, end_cnt_q, end_cnt_d;
  logic                 quiet_q;
  logic [NUM_LANES-1:0] push, full, empty, empty_nx;
  logic                 pop, flush, start, overflow, mismatch;
  logic [CW-1:0]        count   [NUM_LANES];
  logic [LANE_W-1:0]    rd_data [NUM_LANES];
  logic [WORD_W-1:0]    pop_word, dout_d;
  logic                 dvalid_d, fail_d;
  logic [15:0]          wc_d;

  assign state_dbg = state_q;

  // A burst only starts from a cycle where every lane was low, so a burst that
  // was already running when enable rose is ignored until the lanes go quiet
  assign start = enable_i && (state_q == IDLE) && quiet_q && (|lane_valid_i);

  // Lane pushes, common pop and flush control
  always_comb begin
    push  = '0;
    flush = 1'b0;
    if (!enable_i || state_q == FAIL) flush = 1'b1;
    else if (start || state_q == WAIT_ALL || state_q == STREAM) push = lane_valid_i;
    pop = enable_i && (state_q == WAIT_ALL || state_q == STREAM) && (&(~empty));
  end

  // Post-edge emptiness per lane (end checks look at the state after this pop) and the head word
  always_comb begin
    pop_word = '0;
    empty_nx = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      empty_nx[i] = ((count[i] + CW'(push[i] && (!full[i] || pop)) - CW'(pop)) == '0);
      pop_word[i*LANE_W +: LANE_W] = rd_data[i];
    end
  end

  // Burst FSM, skew/end counters and next output register values
  always_comb begin
    state_d    = state_q;
    started_d  = started_q;
    ended_d    = ended_q;
    skew_cnt_d = skew_cnt_q;
    end_cnt_d  = end_cnt_q;
    dvalid_d   = 1'b0;
    dout_d     = data_out;
    fail_d     = align_fail;
    wc_d       = word_count;
    overflow   = !pop && (|(push & full));
    mismatch   = 1'b0;
    if (!enable_i) begin
      state_d    = IDLE;
      started_d  = '0;
      ended_d    = '0;
      skew_cnt_d = '0;
      end_cnt_d  = '0;
      dout_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d    = WAIT_ALL;
            started_d  = lane_valid_i;
            ended_d    = '0;
            skew_cnt_d = '0;
            end_cnt_d  = '0;
            fail_d     = 1'b0;
            wc_d       = '0;
          end
        end
        WAIT_ALL: begin
          started_d = started_q | lane_valid_i;
          if (overflow) begin
            state_d = FAIL;
            fail_d  = 1'b1;
          end else if (&started_q) begin
            state_d = STREAM;
          end else if (skew_cnt_q == SW'(MAX_SKEW)) begin
            state_d = FAIL;
            fail_d  = 1'b1;
          end else begin
            skew_cnt_d = skew_cnt_q + 1'b1;
          end
        end
        STREAM: begin
          ended_d = ended_q | ~lane_valid_i;
          if (|ended_q) end_cnt_d = (end_cnt_q == '1) ? end_cnt_q : end_cnt_q + 1'b1;
          else          end_cnt_d = '0;
          // A lane that has finished and drained while another still holds data was short
          mismatch = (|(ended_d & empty_nx)) && !(&empty_nx);
          if (overflow || mismatch || ((end_cnt_d > SW'(MAX_SKEW)) && (|lane_valid_i))) begin
            state_d = FAIL;
            fail_d  = 1'b1;
          end else if ((&ended_d) && (&empty_nx)) begin
            state_d = IDLE;
          end
        end
        FAIL: begin
          fail_d = 1'b1;
          dout_d = '0;
          if (!(|lane_valid_i)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    if (pop) begin
      dvalid_d = 1'b1;
      dout_d   = pop_word;
      if (word_count != WC_SAT) wc_d = word_count + 1'b1;
    end
  end

  // Registered state, counters and outputs
  always_ff @(posedge byte_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q        <= IDLE;
      started_q      <= '0;
      ended_q        <= '0;
      skew_cnt_q     <= '0;
      end_cnt_q      <= '0;
      quiet_q        <= 1'b0;
      data_out_valid <= 1'b0;
      data_out       <= '0;
      align_fail     <= 1'b0;
      word_count     <= '0;
    end else begin
      state_q        <= state_d;
      started_q      <= started_d;
      ended_q        <= ended_d;
      skew_cnt_q     <= skew_cnt_d;
      end_cnt_q      <= end_cnt_d;
      quiet_q        <= ~(|lane_valid_i);
      data_out_valid <= dvalid_d;
      data_out       <= dout_d;
      align_fail     <= fail_d;
      word_count     <= wc_d;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_skew_fifo #(
      .W     (LANE_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .byte_clk  (byte_clk),
      .sys_rst_n (sys_rst_n),
      .flush     (flush),
      .push      (push[i]),
      .pop       (pop),
      .wr_data   (lane_data_i[i*LANE_W +: LANE_W]),
      .rd_data   (rd_data[i]),
      .full      (full[i]),
      .empty     (empty[i]),
      .count     (count[i])
    );
  end

endmodule

// File: doc/dsi_lane_deskew_packer.md
Name: dsi_lane_deskew_packer

Overview:
Upstream neighbour of the PSRAM data storage controller. It takes per-lane HS byte streams from the four D-PHY lane byte aligners, each with its own valid, and removes inter-lane skew of up to MAX_SKEW byte clocks. It then emits one contiguous 32-bit word stream per HS burst, which drives data_in/data_in_valid of the storage stage. It flags skew, length or overflow faults on align_fail and reports the word count of each burst.

Parameters:
NUM_LANES, 4, lane count; fixed at 4 for the 32-bit output.
LANE_W, 8, bits per lane byte.
MAX_SKEW, 3, maximum tolerated inter-lane start/end skew in byte_clk cycles.
FIFO_DEPTH, 4, per-lane skew buffer depth; must be at least MAX_SKEW+1.

Ports:
byte_clk  in  1  clock; all logic runs in this domain.
sys_rst_n  in  1  asynchronous, active-low reset.
enable_i  in  1  synchronous enable; low forces IDLE and flush.
lane_valid_i  in  4  per-lane HS byte valid.
lane_data_i  in  32  lane n byte on bits [8n+7:8n].
data_out_valid  out  1  aligned word valid; contiguous for the whole burst.
data_out  out  32  {lane3,lane2,lane1,lane0}.
align_fail  out  1  sticky fault flag; cleared at the next burst start.
word_count  out  16  words in the current or last burst; saturates at 0xFFFF.

Behaviour:
- Reset: data_out_valid=0, data_out=0, align_fail=0, word_count=0, state=IDLE, all FIFOs empty, started/ended flags cleared.
- Per lane: an N-deep FIFO.
  - Push when lane_valid_i=1, enable_i=1 and state is WAIT_ALL or STREAM.
  - Pop is common to all lanes and occurs only when every FIFO is non-empty.
- States:
  - IDLE:
    - Any lane_valid_i rising -> WAIT_ALL.
    - On that transition: skew_cnt=0, align_fail=0, word_count=0, that lane's started flag set, its byte pushed.
  - WAIT_ALL:
    - skew_cnt increments each cycle.
    - All started flags set -> STREAM.
    - skew_cnt==MAX_SKEW with any lane not started -> FAIL, align_fail=1.
  - STREAM:
    - When all FIFOs are non-empty: pop, register data_out, data_out_valid=1, word_count+1 (saturating). Otherwise data_out_valid=0.
    - Latency: byte of the latest-starting lane sampled at edge E appears with data_out_valid=1 after edge E+1.
    - A lane whose valid falls sets its ended flag and starts end_cnt (counts from the first end).
    - Normal end: all lanes ended and all FIFOs empty on the same cycle -> IDLE.
    - end_cnt>MAX_SKEW with any lane still valid -> FAIL.
    - Any ended lane has an empty FIFO while another FIFO is non-empty (length mismatch) -> FAIL.
    - Push to a full FIFO -> FAIL.
  - FAIL:
    - align_fail=1, data_out_valid=0, FIFOs flushed, pushes blocked.
    - Exit to IDLE once all lane_valid_i are low.
- Downstream constraint: data_out_valid has no gaps inside a good burst. The storage stage treats each valid run as one record.
- enable_i=0 in any state:
  - Next edge: state=IDLE, FIFOs flushed, data_out_valid=0.
  - align_fail and word_count hold their values.
  - A burst already in progress when enable rises is ignored until all lanes go low (IDLE requires a fresh rising edge).
- Simultaneous events:
  - Lane start and lane end in the same cycle as the final pop: the end is evaluated after the pop.
  - FAIL takes priority over normal end.
- Mid-operation reset: asynchronous; all state returns to reset values immediately.
- data_out holds its last value when data_out_valid=0. In FAIL and on enable_i=0 it is cleared to 0.

Decomposition:
- Package dsi_deskew_pkg holds:
  - state enum {IDLE, WAIT_ALL, STREAM, FAIL};
  - NUM_LANES, LANE_W, and the word width localparam;
  - the word_count saturation constant.
- Sub-module lane_skew_fifo: a synchronous FIFO with push, pop, flush, full, empty and data outputs. It is instantiated NUM_LANES times; the top holds the FSM, counters and output register.

Test Plan:
- Zero skew, all lanes valid 8 cycles, lane n byte k = 0x10*n+k:
  - 8 contiguous valid words; first word 0x30201000, last word 0x37271707;
  - latency 2 edges; word_count=8; align_fail=0.
- Lane0 starts at t, lanes 1/2/3 at t+1/t+2/t+3, 6 bytes each:
  - 6 contiguous words with first word 0x30201000;
  - data_out_valid first asserted after edge t+4; align_fail=0.
- Lane2 starts 4 cycles after lane0 (MAX_SKEW=3):
  - align_fail=1, no data_out_valid, FAIL held until all lanes are low;
  - a following clean burst clears align_fail and streams normally.
- Lane1 sends 5 bytes, others 6:
  - 5 words output, then align_fail=1, word_count=5.
- Back-to-back 4-word bursts separated by 1 idle cycle:
  - two separate 4-cycle valid runs; word_count=4 after each.
- enable_i dropped mid-burst:
  - data_out_valid=0 at the next edge; IDLE with no new start until all lanes go low.
- Asynchronous reset mid-stream:
  - all outputs 0 immediately.
